symbol_stream_checker: RTL and testbench

SYMBOL_STREAM_CHECKER -- requirements
Module: symbol_stream_checker

---
 rtl/symbol_stream_checker.sv | 142 ++++++++++++++
 tb/tb_symbol_stream_checker.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/symbol_stream_checker.sv
// Multi-lane 8b/10b line monitor: running-disparity, run-length and comma checks
// with per-lane sticky flags and saturating error counters.
module symbol_stream_checker #(
    parameter int LANES     = 1,
    parameter int MAX_RUN   = 5,
    parameter int ERR_CNT_W = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic                       BitCLK_10,
    input  logic                       Reset,
    input  logic [LANES-1:0]           TxValid,
    input  logic [10*LANES-1:0]        TxParallel_10,
    input  logic [LANES-1:0]           TxDataK,
    input  logic [8*LANES-1:0]         TxParallel_8,
    input  logic                       ErrClr,
    output logic [LANES-1:0]           RdErr,
    output logic [LANES-1:0]           RunErr,
    output logic [LANES-1:0]           CommaDet,
    output logic [LANES-1:0]           RdState,
    output logic [LANES-1:0]           ErrSticky,
    output logic [ERR_CNT_W*LANES-1:0] ErrCnt
);

    localparam int              RUN_W     = $clog2(MAX_RUN + 2);
    localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(MAX_RUN + 1);

    for (genvar n = 0; n < LANES; n++) begin : g_lane
        logic [9:0]           sym;
        logic [7:0]           byte_val;
        logic [3:0]           ones;
        logic                 rd_next;
        logic                 rd_err_next;
        logic                 run_last_next;
        logic [RUN_W-1:0]     run_cnt_next;
        logic                 run_err_next;
        logic                 comma_next;

        logic                 rd_q;
        logic                 run_last_q;
        logic [RUN_W-1:0]     run_cnt_q;
        logic                 rd_err_q;
        logic                 run_err_q;
        logic                 comma_q;
        logic                 sticky_q;
        logic [ERR_CNT_W-1:0] cnt_q;

        assign sym      = TxParallel_10[10*n +: 10];
        assign byte_val = TxParallel_8[8*n +: 8];

        // Disparity in terms of ones: d=0 <-> 5 ones, d=+2 <-> 6, d=-2 <-> 4.
        always_comb begin
            // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
            ones        = '0;
            rd_next     = rd_q;
            rd_err_next = 1'b0;
            for (int i = 0; i < 10; i++) begin
                ones = ones + 4'(sym[i]);
            end
            if (ones == 4'd5) begin
                rd_next = rd_q;
            end else if (ones == 4'd6 && !rd_q) begin
                rd_next = 1'b1;
            end else if (ones == 4'd4 && rd_q) begin
                rd_next = 1'b0;
            end else begin
                rd_err_next = 1'b1;
                rd_next     = (ones > 4'd5);
            end
        end

        // Walk the ten bits in line order, continuing the run left by the previous symbol.
        always_comb begin
            logic bit_v;
            // NOTE: blocking assignments here because each bit's result feeds the next iteration.
            run_last_next = run_last_q;
            run_cnt_next  = run_cnt_q;
            run_err_next  = 1'b0;
            bit_v         = 1'b0;
            for (int i = 0; i < 10; i++) begin
                bit_v = (MSB_FIRST != 0) ? sym[9-i] : sym[i];
                if (run_cnt_next != '0 && bit_v == run_last_next) begin
                    if (run_cnt_next != RUN_LIMIT) begin
                        run_cnt_next = run_cnt_next + RUN_W'(1);
                    end
                end else begin
                    run_cnt_next = RUN_W'(1);
                end
                run_last_next = bit_v;
                if (run_cnt_next == RUN_LIMIT) begin
                    run_err_next = 1'b1;
                end
            end
        end

        assign comma_next = TxDataK[n] &&
                            (byte_val == 8'h3C || byte_val == 8'hBC || byte_val == 8'hFC);

        always_ff @(posedge BitCLK_10 or negedge Reset) begin
            // NOTE: non-blocking assignments for all registered state.
            if (!Reset) begin
                rd_q       <= 1'b0;
                run_last_q <= 1'b0;
                run_cnt_q  <= '0;
                rd_err_q   <= 1'b0;
                run_err_q  <= 1'b0;
                comma_q    <= 1'b0;
                sticky_q   <= 1'b0;
                cnt_q      <= '0;
            end else begin
                rd_err_q  <= 1'b0;
                run_err_q <= 1'b0;
                comma_q   <= 1'b0;
                if (TxValid[n]) begin
                    rd_q       <= rd_next;
                    run_last_q <= run_last_next;
                    run_cnt_q  <= run_cnt_next;
                    rd_err_q   <= rd_err_next;
                    run_err_q  <= run_err_next;
                    comma_q    <= comma_next;
                end
                // Clear wins over a same-cycle error; disparity and run state are untouched.
                if (ErrClr) begin
                    cnt_q    <= '0;
                    sticky_q <= 1'b0;
                end else if (TxValid[n] && (rd_err_next || run_err_next)) begin
                    sticky_q <= 1'b1;
                    if (cnt_q != '1) begin
                        cnt_q <= cnt_q + ERR_CNT_W'(1);
                    end
                end
            end
        end

        assign RdErr[n]                          = rd_err_q;
        assign RunErr[n]                         = run_err_q;
        assign CommaDet[n]                       = comma_q;
        assign RdState[n]                        = rd_q;
        assign ErrSticky[n]                      = sticky_q;
        assign ErrCnt[n*ERR_CNT_W +: ERR_CNT_W]  = cnt_q;
    end

endmodule

// File: tb/tb_symbol_stream_checker.sv
// Bench for symbol_stream_checker: two lanes, 4-bit counters, MSB-first line order.
module tb_symbol_stream_checker;

    typedef struct packed {
        logic [1:0] valid;
        logic [9:0] s0;
        logic [9:0] s1;
        logic [1:0] k;
        logic [7:0] b0;
        logic [7:0] b1;
        logic       clr;
    } stim_t;

    typedef struct packed {
        logic [1:0] rd_err;
        logic [1:0] run_err;
        logic [1:0] comma;
        logic [1:0] rd_state;
        logic [1:0] sticky;
        logic [3:0] cnt0;
        logic [3:0] cnt1;
    } exp_t;

    typedef struct packed {
        stim_t stim;
        exp_t  exp;
    } vec_t;

    logic        BitCLK_10;
    logic        Reset;
    logic [1:0]  TxValid;
    logic [19:0] TxParallel_10;
    logic [1:0]  TxDataK;
    logic [15:0] TxParallel_8;
    logic        ErrClr;
    logic [1:0]  RdErr;
    logic [1:0]  RunErr;
    logic [1:0]  CommaDet;
    logic [1:0]  RdState;
    logic [1:0]  ErrSticky;
    logic [7:0]  ErrCnt;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb_q[$];
    vec_t table_v[12];

    symbol_stream_checker #(
        .LANES    (2),
        .MAX_RUN  (5),
        .ERR_CNT_W(4),
        .MSB_FIRST(1)
    ) dut (
        .BitCLK_10    (BitCLK_10),
        .Reset        (Reset),
        .TxValid      (TxValid),
        .TxParallel_10(TxParallel_10),
        .TxDataK      (TxDataK),
        .TxParallel_8 (TxParallel_8),
        .ErrClr       (ErrClr),
        .RdErr        (RdErr),
        .RunErr       (RunErr),
        .CommaDet     (CommaDet),
        .RdState      (RdState),
        .ErrSticky    (ErrSticky),
        .ErrCnt       (ErrCnt)
    );

    initial BitCLK_10 = 1'b0;
    always #5 BitCLK_10 = ~BitCLK_10;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    function automatic stim_t mk_stim(input logic [1:0] valid, input logic [9:0] s0,
                                      input logic [9:0] s1, input logic [1:0] k,
                                      input logic [7:0] b0, input logic [7:0] b1,
                                      input logic clr);
        stim_t s;
        s.valid = valid; s.s0 = s0; s.s1 = s1; s.k = k; s.b0 = b0; s.b1 = b1; s.clr = clr;
        return s;
    endfunction

    function automatic exp_t mk_exp(input logic [1:0] rd_err, input logic [1:0] run_err,
                                    input logic [1:0] comma, input logic [1:0] rd_state,
                                    input logic [1:0] sticky, input logic [3:0] cnt0,
                                    input logic [3:0] cnt1);
        exp_t e;
        e.rd_err = rd_err; e.run_err = run_err; e.comma = comma; e.rd_state = rd_state;
        e.sticky = sticky; e.cnt0 = cnt0; e.cnt1 = cnt1;
        return e;
    endfunction

    task automatic compare_outputs(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            check({tag, ".scoreboard_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check({tag, ".RdErr"},     32'(RdErr),       32'(e.rd_err));
            check({tag, ".RunErr"},    32'(RunErr),      32'(e.run_err));
            check({tag, ".CommaDet"},  32'(CommaDet),    32'(e.comma));
            check({tag, ".RdState"},   32'(RdState),     32'(e.rd_state));
            check({tag, ".ErrSticky"}, 32'(ErrSticky),   32'(e.sticky));
            check({tag, ".ErrCnt0"},   32'(ErrCnt[3:0]), 32'(e.cnt0));
            check({tag, ".ErrCnt1"},   32'(ErrCnt[7:4]), 32'(e.cnt1));
        end
    endtask

    task automatic apply(input stim_t s, input exp_t e, input string tag);
        @(negedge BitCLK_10);
        TxValid       = s.valid;
        TxParallel_10 = {s.s1, s.s0};
        TxDataK       = s.k;
        TxParallel_8  = {s.b1, s.b0};
        ErrClr        = s.clr;
        sb_q.push_back(e);
        @(posedge BitCLK_10);
        #1;
        compare_outputs(tag);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".RdErr"},     32'(RdErr),     32'd0);
        check({tag, ".RunErr"},    32'(RunErr),    32'd0);
        check({tag, ".CommaDet"},  32'(CommaDet),  32'd0);
        check({tag, ".RdState"},   32'(RdState),   32'd0);
        check({tag, ".ErrSticky"}, 32'(ErrSticky), 32'd0);
        check({tag, ".ErrCnt"},    32'(ErrCnt),    32'd0);
    endtask

    initial begin
        Reset = 1'b0; TxValid = '0; TxParallel_10 = '0; TxDataK = '0;
        TxParallel_8 = '0; ErrClr = 1'b0;

        // Stimulus and hand-derived expectations; bit 1 of each 2-bit field is lane 1.
        table_v[0]  = {mk_stim(2'b01, 10'h0FA, 10'h000, 2'b01, 8'hBC, 8'h00, 1'b0),
                       mk_exp(2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 4'd0, 4'd0)};
        table_v[1]  = {mk_stim(2'b01, 10'h305, 10'h000, 2'b01, 8'hBC, 8'h00, 1'b0),
                       mk_exp(2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 4'd0, 4'd0)};
        table_v[2]  = {mk_stim(2'b11, 10'h0FA, 10'h0FA, 2'b01, 8'hBC, 8'h00, 1'b0),
                       mk_exp(2'b00, 2'b00, 2'b01, 2'b11, 2'b00, 4'd0, 4'd0)};
        table_v[3]  = {mk_stim(2'b11, 10'h0FA, 10'h3FF, 2'b01, 8'hBC, 8'h00, 1'b0),
                       mk_exp(2'b11, 2'b10, 2'b01, 2'b11, 2'b11, 4'd1, 4'd1)};
        table_v[4]  = {mk_stim(2'b11, 10'h3E0, 10'h000, 2'b00, 8'h00, 8'h00, 1'b0),
                       mk_exp(2'b10, 2'b10, 2'b00, 2'b01, 2'b11, 4'd1, 4'd2)};
        table_v[5]  = {mk_stim(2'b00, 10'h000, 10'h000, 2'b01, 8'hBC, 8'h00, 1'b0),
                       mk_exp(2'b00, 2'b00, 2'b00, 2'b01, 2'b11, 4'd1, 4'd2)};
        table_v[6]  = {mk_stim(2'b01, 10'h15A, 10'h000, 2'b00, 8'h00, 8'h00, 1'b0),
                       mk_exp(2'b00, 2'b01, 2'b00, 2'b01, 2'b11, 4'd2, 4'd2)};
        table_v[7]  = {mk_stim(2'b01, 10'h3E0, 10'h000, 2'b01, 8'h1C, 8'h00, 1'b0),
                       mk_exp(2'b00, 2'b00, 2'b00, 2'b01, 2'b11, 4'd2, 4'd2)};
        table_v[8]  = {mk_stim(2'b01, 10'h15A, 10'h000, 2'b00, 8'hBC, 8'h00, 1'b0),
                       mk_exp(2'b00, 2'b01, 2'b00, 2'b01, 2'b11, 4'd3, 4'd2)};
        table_v[9]  = {mk_stim(2'b10, 10'h000, 10'h3E0, 2'b10, 8'h00, 8'h3C, 1'b0),
                       mk_exp(2'b00, 2'b00, 2'b10, 2'b01, 2'b11, 4'd3, 4'd2)};
        table_v[10] = {mk_stim(2'b10, 10'h000, 10'h2AA, 2'b10, 8'h00, 8'hFC, 1'b0),
                       mk_exp(2'b00, 2'b00, 2'b10, 2'b01, 2'b11, 4'd3, 4'd2)};
        table_v[11] = {mk_stim(2'b01, 10'h305, 10'h000, 2'b01, 8'hBC, 8'h00, 1'b0),
                       mk_exp(2'b00, 2'b00, 2'b01, 2'b00, 2'b11, 4'd3, 4'd2)};

        repeat (2) @(posedge BitCLK_10);
        #1;
        check_reset_values("reset");
        @(negedge BitCLK_10);
        Reset = 1'b1;

        for (int i = 0; i < 12; i++) begin
            apply(table_v[i].stim, table_v[i].exp, $sformatf("vec%0d", i));
        end

        // Clear with no traffic: counters and flags drop, disparity is kept.
        apply(mk_stim(2'b00, 10'h000, 10'h000, 2'b00, 8'h00, 8'h00, 1'b1),
              mk_exp(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 4'd0, 4'd0), "clr_idle");

        // Back-to-back errors on both lanes: counters saturate at 15.
        for (int i = 0; i < 20; i++) begin
            apply(mk_stim(2'b11, 10'h000, 10'h3FF, 2'b00, 8'h00, 8'h00, 1'b0),
                  mk_exp(2'b11, 2'b11, 2'b00, 2'b10, 2'b11,
                         4'((i + 1 > 15) ? 15 : i + 1), 4'((i + 1 > 15) ? 15 : i + 1)),
                  $sformatf("sat%0d", i));
        end

        // Clear coincident with a 21st error: clear wins, pulses still fire.
        apply(mk_stim(2'b11, 10'h000, 10'h3FF, 2'b00, 8'h00, 8'h00, 1'b1),
              mk_exp(2'b11, 2'b11, 2'b00, 2'b10, 2'b00, 4'd0, 4'd0), "clr_with_err");
        apply(mk_stim(2'b00, 10'h000, 10'h000, 2'b00, 8'h00, 8'h00, 1'b1),
              mk_exp(2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 4'd0, 4'd0), "clr_keeps_rd");

        // Saturated run carries into lane 0; lane 1 keeps violating.
        apply(mk_stim(2'b11, 10'h0FA, 10'h3FF, 2'b00, 8'h00, 8'h00, 1'b0),
              mk_exp(2'b10, 2'b11, 2'b00, 2'b11, 2'b11, 4'd1, 4'd1), "pre_reset");

        // Asynchronous reset mid-cycle must clear outputs without a clock edge.
        @(negedge BitCLK_10);
        TxValid = 2'b00;
        ErrClr  = 1'b0;
        #2;
        Reset = 1'b0;
        #1;
        check_reset_values("mid_reset");
        @(negedge BitCLK_10);
        Reset = 1'b1;

        // From RD-, 0x305 is a disparity error; lane 1 starts a fresh run (no run error).
        apply(mk_stim(2'b11, 10'h305, 10'h3E0, 2'b00, 8'h00, 8'h00, 1'b0),
              mk_exp(2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 4'd1, 4'd0), "post_reset");

        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
